load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 190 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: turns one byte/half/word access request into a single
// handshaked memory transaction, formats load data and flags illegal or
// timed-out accesses.
//
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   start            - request an access (accepted only while idle)
//   is_store, funct3 - access kind and size (B, H, W, BU, HU)
//   addr, wdata      - byte address and store data
//   busy, done, err  - status; done pulses one cycle, err valid with done
//   rdata            - formatted load result
//   mem_*            - memory request channel (req/we/addr/be/wdata, ack/rdata)
module load_store_unit #(
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CntW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
    logic [31:0]     rdata_q, rdata_d;

    logic            is_store_q;
    logic [2:0]      funct3_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;

    logic            capture;
    logic            access_legal;
    logic [31:0]     lane_data;
    logic [31:0]     load_fmt;
    logic [3:0]      be_raw;
    logic [31:0]     wdata_rep;

    // Legality is judged on the live request so an illegal access can go
    // straight to DONE without ever touching memory.
    always_comb begin
        access_legal = 1'b0;
        case (funct3)
            3'b000:  access_legal = 1'b1;
            3'b001:  access_legal = ~addr[0];
            3'b010:  access_legal = (addr[1:0] == 2'b00);
            3'b100:  access_legal = ~is_store;
            3'b101:  access_legal = ~is_store & ~addr[0];
            default: access_legal = 1'b0;
        endcase
    end

    // Move the addressed lane down to bit 0, then extend per access type.
    assign lane_data = mem_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        load_fmt = mem_rdata;
        case (funct3_q)
            3'b000:  load_fmt = {{24{lane_data[7]}}, lane_data[7:0]};
            3'b001:  load_fmt = {{16{lane_data[15]}}, lane_data[15:0]};
            3'b100:  load_fmt = {24'h000000, lane_data[7:0]};
            3'b101:  load_fmt = {16'h0000, lane_data[15:0]};
            default: load_fmt = mem_rdata;
        endcase
    end

    always_comb begin
        be_raw    = 4'b1111;
        wdata_rep = wdata_q;
        case (funct3_q[1:0])
            2'b00: begin
                be_raw    = 4'b0001 << addr_q[1:0];
                wdata_rep = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be_raw    = 4'b0011 << addr_q[1:0];
                wdata_rep = {2{wdata_q[15:0]}};
            end
            default: begin
                be_raw    = 4'b1111;
                wdata_rep = wdata_q;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        capture = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    capture = 1'b1;
                    cnt_d   = '0;
                    if (access_legal) begin
                        state_d = StReq;
                        err_d   = 1'b0;
                    end else begin
                        state_d = StDone;
                        err_d   = 1'b1;
                    end
                end
            end
            StReq: begin
                // An ack on the final allowed cycle still wins over the timeout.
                if (mem_ack) begin
                    state_d = StDone;
                    err_d   = 1'b0;
                    if (!is_store_q) begin
                        rdata_d = load_fmt;
                    end
                end else if (cnt_q == CntLast) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            is_store_q <= 1'b0;
            funct3_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            if (capture) begin
                is_store_q <= is_store;
                funct3_q   <= funct3;
                addr_q     <= addr;
                wdata_q    <= wdata;
            end
        end
    end

    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign err       = done & err_q;
    assign rdata     = rdata_q;
    assign mem_req   = (state_q == StReq);
    assign mem_we    = mem_req & is_store_q;
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_be    = mem_req ? be_raw : 4'b0000;
    assign mem_wdata = wdata_rep;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed corner cases plus
// randomized accesses compared against a behavioural access model.
module tb_load_store_unit;

    localparam int ACK_TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int tests_run = 0;
    int tests_failed = 0;
    logic [31:0] model_rdata;

    load_store_unit #(.ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_store  (is_store),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int acc_size(input logic [2:0] f3);
        if (f3[1:0] == 2'd0) return 1;
        if (f3[1:0] == 2'd1) return 2;
        return 4;
    endfunction

    function automatic bit model_legal(input bit st, input logic [2:0] f3, input logic [31:0] a);
        bit kind_ok;
        if (st) kind_ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
        else    kind_ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        return kind_ok && ((a % acc_size(f3)) == 0);
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        int m;
        m = ((1 << acc_size(f3)) - 1) << (a % 4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] w);
        if (acc_size(f3) == 1) return (w & 32'hFF) * 32'h0101_0101;
        if (acc_size(f3) == 2) return (w & 32'hFFFF) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] word);
        logic [31:0] v;
        v = word >> (8 * (a % 4));
        if (acc_size(f3) == 1) begin
            v = v & 32'hFF;
            if (f3 == 3'd0 && v >= 32'h80) v = v + 32'hFFFF_FF00;
        end else if (acc_size(f3) == 2) begin
            v = v & 32'hFFFF;
            if (f3 == 3'd1 && v >= 32'h8000) v = v + 32'hFFFF_0000;
        end
        return v;
    endfunction

    // Issue one access from an idle negedge; ack_delay = REQ cycle that
    // carries mem_ack (0 = never). Returns at an idle negedge.
    task automatic do_access(input bit st, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] w, input logic [31:0] word, input int ack_delay);
        bit lgl;
        int req_cycles;
        int cyc;
        bit seen_done;
        bit exp_err;
        int exp_lat;
        int exp_req;
        lgl = model_legal(st, f3, a);
        req_cycles = 0;
        cyc = 0;
        seen_done = 1'b0;
        start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = w; mem_ack = 1'b0;
        @(negedge clk);
        // Scramble request inputs: the unit must work from its captured copy.
        start = 1'b0; is_store = $urandom; funct3 = $urandom; addr = $urandom; wdata = $urandom;
        for (int i = 0; i < ACK_TIMEOUT + 5 && !seen_done; i++) begin
            cyc++;
            if (mem_req) begin
                req_cycles++;
                tests_run++;
                if (mem_addr !== (a & 32'hFFFF_FFFC) || mem_be !== model_be(f3, a) ||
                    mem_we !== st || busy !== 1'b1 || done !== 1'b0 ||
                    (st && mem_wdata !== model_wdata(f3, w))) begin
                    tests_failed++;
                    $display("FAIL req_drive cyc=%0d: addr=%h be=%b we=%b wd=%h busy=%b done=%b, required addr=%h be=%b we=%b wd=%h",
                             req_cycles, mem_addr, mem_be, mem_we, mem_wdata, busy, done,
                             a & 32'hFFFF_FFFC, model_be(f3, a), st, model_wdata(f3, w));
                end
                if (ack_delay != 0 && req_cycles == ack_delay) begin
                    mem_ack = 1'b1; mem_rdata = word;
                end else begin
                    mem_ack = 1'b0; mem_rdata = $urandom;
                end
            end else begin
                mem_ack = 1'b0;
            end
            if (done) seen_done = 1'b1;
            else @(negedge clk);
        end

        if (!lgl) begin
            exp_err = 1'b1; exp_lat = 1; exp_req = 0;
        end else if (ack_delay == 0 || ack_delay > ACK_TIMEOUT) begin
            exp_err = 1'b1; exp_lat = ACK_TIMEOUT + 1; exp_req = ACK_TIMEOUT; model_rdata = 0;
        end else begin
            exp_err = 1'b0; exp_lat = ack_delay + 1; exp_req = ack_delay;
            if (!st) model_rdata = model_load(f3, a, word);
        end

        tests_run++;
        if (!seen_done) begin
            tests_failed++;
            $display("FAIL done_timeout: no done within bound, required done after %0d cycles", exp_lat);
        end else begin
            tests_run += 3;
            if (cyc !== exp_lat || req_cycles !== exp_req) begin
                tests_failed++;
                $display("FAIL latency: done at %0d req_cycles=%0d, required %0d and %0d",
                         cyc, req_cycles, exp_lat, exp_req);
            end
            if (err !== exp_err) begin
                tests_failed++;
                $display("FAIL err: got %b, required %b", err, exp_err);
            end
            if (rdata !== model_rdata) begin
                tests_failed++;
                $display("FAIL rdata: got %h, required %h", rdata, model_rdata);
            end
        end

        // In DONE: a new start and a stray ack must both be ignored.
        start = 1'b1; is_store = 1'b0; funct3 = 3'd2; addr = 32'h40; mem_ack = 1'b1;
        @(negedge clk);
        start = 1'b0; mem_ack = 1'b0;
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0 || mem_req !== 1'b0 || mem_be !== 4'b0000 ||
            mem_we !== 1'b0 || rdata !== model_rdata) begin
            tests_failed++;
            $display("FAIL post_done: done=%b busy=%b req=%b be=%b we=%b rdata=%h, required 0 0 0 0000 0 %h",
                     done, busy, mem_req, mem_be, mem_we, rdata, model_rdata);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; is_store = 1'b0; funct3 = 3'd0; addr = 32'h0;
        wdata = 32'h0; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || mem_req !== 1'b0 ||
            mem_we !== 1'b0 || rdata !== 32'h0 || mem_be !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_state: busy=%b done=%b err=%b req=%b we=%b rdata=%h be=%b, required all zero",
                     busy, done, err, mem_req, mem_we, rdata, mem_be);
        end
        rst = 1'b0; start = 1'b0; mem_ack = 1'b0;
        model_rdata = 32'h0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        do_access(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 1);  // LB
        do_access(1'b0, 3'b101, 32'h202, 32'h0, 32'h8001_0000, 2);  // LHU
        do_access(1'b1, 3'b000, 32'h11, 32'h0000_00AB, 32'h0, 3);   // SB
        do_access(1'b0, 3'b010, 32'h6, 32'h0, 32'h0, 1);            // LW misaligned
        do_access(1'b1, 3'b100, 32'h8, 32'h1, 32'h0, 1);            // SBU illegal
        do_access(1'b0, 3'b001, 32'h31, 32'h0, 32'h0, 1);           // LH misaligned
        do_access(1'b0, 3'b001, 32'h32, 32'h0, 32'h9ABC_0000, 16);  // ack on timeout cycle
    endtask

    task automatic test_timeout();
        do_access(1'b0, 3'b000, 32'h77, 32'h0, 32'h1234_5678, 0);
        // Late acks while idle must not produce anything.
        mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if (done !== 1'b0 || busy !== 1'b0 || rdata !== 32'h0) begin
                tests_failed++;
                $display("FAIL late_ack: done=%b busy=%b rdata=%h, required 0 0 0", done, busy, rdata);
            end
        end
        mem_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        do_access(1'b0, 3'b010, 32'h100, 32'h0, 32'hCAFE_F00D, 1);
        do_access(1'b1, 3'b001, 32'h102, 32'h1357_2468, 32'h0, 1);
        do_access(1'b0, 3'b100, 32'h101, 32'h0, 32'h0000_F700, 1);
    endtask

    task automatic test_reset_mid();
        do_access(1'b0, 3'b010, 32'h20, 32'h0, 32'h1234_5678, 1);
        start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h40;
        @(negedge clk);  // 1st REQ cycle: issue a store while busy
        start = 1'b1; is_store = 1'b1; funct3 = 3'b000; addr = 32'h55; wdata = 32'hEE;
        @(negedge clk);  // 2nd REQ cycle
        start = 1'b0;
        tests_run++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h40) begin
            tests_failed++;
            $display("FAIL busy_start: req=%b we=%b addr=%h, required 1 0 00000040",
                     mem_req, mem_we, mem_addr);
        end
        rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        rst = 1'b0; mem_ack = 1'b0;
        model_rdata = 32'h0;
        tests_run++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL mid_reset: req=%b busy=%b done=%b rdata=%h, required 0 0 0 0",
                     mem_req, busy, done, rdata);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests_run++;
            if (done !== 1'b0 || mem_req !== 1'b0 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL after_reset: done=%b req=%b busy=%b, required 0 0 0", done, mem_req, busy);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            bit          st;
            logic [2:0]  f3;
            logic [31:0] a;
            int          dly;
            st = $urandom_range(0, 1);
            f3 = $urandom_range(0, 7);
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~((acc_size(f3) - 1));
            dly = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, ACK_TIMEOUT);
            do_access(st, f3, a, $urandom, $urandom, dly);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
